// File: rtl/rf_write_sched_pkg.sv
// Shared constants and buffer-entry type for the register-file write scheduler.
package rf_write_sched_pkg;

  localparam int DW_DEF           = 16;
  localparam int AW_DEF           = 2;
  localparam int DEPTH_DEF        = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  // Buffer entries use the default widths; the top's DW/AW follow these defaults.
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } rf_entry_t;

endpackage

// File: rtl/rf_write_sched_if.sv
// Writeback, secondary-writer, decode and RF write-port signals of the write scheduler.
interface rf_write_sched_if
  import rf_write_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          mc_valid;
  logic          mc_ready;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_data;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [AW-1:0] id_dst;
  logic          hazard;
  logic          wb_stall;
  logic          rf_write;
  logic [AW-1:0] rf_addr3;
  logic [DW-1:0] rf_data3;

  modport master (
    output wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
           rd_addr1, rd_addr2, id_dst,
    input  mc_ready, hazard, wb_stall, rf_write, rf_addr3, rf_data3
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
           rd_addr1, rd_addr2, id_dst,
    output mc_ready, hazard, wb_stall, rf_write, rf_addr3, rf_data3
  );

endinterface

// File: rtl/rf_sched_fifo.sv
// Secondary-writer buffer: circular FIFO exposing per-slot valid/addr for the pending vector.
module rf_sched_fifo
  import rf_write_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  rf_entry_t                      push_entry,
  input  logic                           pop,
  output rf_entry_t                      head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [DEPTH-1:0]               slot_valid,
  output logic [DEPTH-1:0][AW_DEF-1:0]   slot_addr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rf_entry_t        mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Control state is reset; storage is not, so stale entries are simply marked invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_inc(rd_ptr);
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    head       = mem[rd_ptr];
    slot_valid = valid;
    for (int i = 0; i < DEPTH; i++) slot_addr[i] = mem[i].addr;
  end

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: writeback wins, buffered secondary writes fill idle slots.
// Optional RF_SCHED_STATS_EN adds saturating stat_mc_writes / stat_stall_cycles counters.
module rf_write_sched
  import rf_write_sched_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int AW           = AW_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_sched_if.slave   bus
`ifdef RF_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_mc_writes,
  output logic [15:0]       stat_stall_cycles
`endif
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int NREG = 1 << AW;

  rf_entry_t                   head;
  rf_entry_t                   push_entry;
  logic [CW-1:0]               count;
  logic [DEPTH-1:0]            slot_valid;
  logic [DEPTH-1:0][AW_DEF-1:0] slot_addr;
  logic                        push;
  logic                        pop;
  logic                        wb_win;
  logic                        buf_empty;
  logic [NREG-1:0]             pending;
  logic [SW-1:0]               starve_cnt;
  logic [SW-1:0]               starve_next;
  logic                        stall_next;

  rf_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .slot_valid (slot_valid),
    .slot_addr  (slot_addr)
  );

  // Accept only from registered occupancy; pushed data is never bypassed to the port.
  always_comb begin
    bus.mc_ready    = (count < CW'(DEPTH));
    push            = bus.mc_valid && bus.mc_ready;
    push_entry.addr = bus.mc_addr;
    push_entry.data = bus.mc_data;
  end

  // Writeback owns the port whenever present; the buffer head drains only into idle cycles.
  always_comb begin
    buf_empty    = (count == '0);
    wb_win       = bus.wb_valid && !reset;
    pop          = !wb_win && !buf_empty;
    bus.rf_write = 1'b0;
    bus.rf_addr3 = '0;
    bus.rf_data3 = '0;
    if (wb_win) begin
      bus.rf_write = 1'b1;
      bus.rf_addr3 = bus.wb_addr;
      bus.rf_data3 = bus.wb_data;
    end else if (!buf_empty) begin
      bus.rf_write = 1'b1;
      bus.rf_addr3 = head.addr;
      bus.rf_data3 = head.data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) pending[slot_addr[i]] = 1'b1;
    end
    bus.hazard = pending[bus.rd_addr1] | pending[bus.rd_addr2] | pending[bus.id_dst];
  end

  // The stall flag rises when blocking reaches the limit and holds until the head finally drains.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || buf_empty) begin
      starve_next = '0;
    end else if (wb_win && (starve_cnt < SW'(STARVE_LIMIT))) begin
      starve_next = starve_cnt + SW'(1);
    end
    stall_next = bus.wb_stall;
    if (pop) begin
      stall_next = 1'b0;
    end else if (starve_next == SW'(STARVE_LIMIT)) begin
      stall_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt   <= '0;
      bus.wb_stall <= 1'b0;
    end else begin
      starve_cnt   <= starve_next;
      bus.wb_stall <= stall_next;
    end
  end

`ifdef RF_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_mc_writes    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (pop && (stat_mc_writes != 16'hFFFF))
        stat_mc_writes <= stat_mc_writes + 16'd1;
      if (bus.wb_stall && (stat_stall_cycles != 16'hFFFF))
        stat_stall_cycles <= stat_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: directed scenarios plus randomized traffic vs a queue model.
module tb_rf_write_sched;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  rf_write_sched_if #(.DW(DW), .AW(AW)) bus ();

`ifdef RF_SCHED_STATS_EN
  logic [15:0] stat_mc_writes;
  logic [15:0] stat_stall_cycles;
`endif

  rf_write_sched #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RF_SCHED_STATS_EN
    ,
    .stat_mc_writes    (stat_mc_writes),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the buffer is a plain queue; starvation is a blocked-cycle tally.
  ent_t m_q[$];
  int   m_starve;
  bit   m_stall;
  int   m_writes;
  int   m_stall_cyc;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit m_hazard(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] dst);
    foreach (m_q[i]) begin
      if (m_q[i].addr == a1 || m_q[i].addr == a2 || m_q[i].addr == dst) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelClear();
    m_q.delete();
    m_starve    = 0;
    m_stall     = 1'b0;
    m_writes    = 0;
    m_stall_cyc = 0;
  endtask

  task automatic applyStimulus(input bit wbv, input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                               input bit mcv, input logic [AW-1:0] mca, input logic [DW-1:0] mcd,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] dst);
    bit            e_write;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            n;
    int            prev;
    bit            do_pop;
    ent_t          e;
    @(negedge clk);
    bus.wb_valid = wbv;  bus.wb_addr = wba;  bus.wb_data = wbd;
    bus.mc_valid = mcv;  bus.mc_addr = mca;  bus.mc_data = mcd;
    bus.rd_addr1 = r1;   bus.rd_addr2 = r2;  bus.id_dst  = dst;
    #1;
    n = m_q.size();
    e_write = 1'b0; e_addr = '0; e_data = '0;
    if (wbv) begin
      e_write = 1'b1; e_addr = wba; e_data = wbd;
    end else if (n > 0) begin
      e_write = 1'b1; e_addr = m_q[0].addr; e_data = m_q[0].data;
    end
    checkOutput("mc_ready", bus.mc_ready, (n < DEPTH));
    checkOutput("hazard",   bus.hazard,   m_hazard(r1, r2, dst));
    checkOutput("wb_stall", bus.wb_stall, m_stall);
    checkOutput("rf_write", bus.rf_write, e_write);
    checkOutput("rf_addr3", bus.rf_addr3, e_addr);
    checkOutput("rf_data3", bus.rf_data3, e_data);
`ifdef RF_SCHED_STATS_EN
    checkOutput("stat_mc_writes",    stat_mc_writes,    m_writes);
    checkOutput("stat_stall_cycles", stat_stall_cycles, m_stall_cyc);
`endif
    @(posedge clk);
    do_pop = !wbv && (n > 0);
    if (m_stall && m_stall_cyc < 65535) m_stall_cyc++;
    if (do_pop) begin
      void'(m_q.pop_front());
      if (m_writes < 65535) m_writes++;
    end
    prev = m_starve;
    if (do_pop || n == 0) m_starve = 0;
    else if (wbv) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    if (do_pop) m_stall = 1'b0;
    else if (prev < LIMIT && m_starve == LIMIT) m_stall = 1'b1;
    if (mcv && n < DEPTH) begin
      e.addr = mca; e.data = mcd;
      m_q.push_back(e);
    end
  endtask

  // Asserts reset between clock edges and checks the outputs respond without waiting for a clock.
  task automatic doReset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mc_ready", bus.mc_ready, 1'b1);
    checkOutput("rst_hazard",   bus.hazard,   1'b0);
    checkOutput("rst_wb_stall", bus.wb_stall, 1'b0);
    checkOutput("rst_rf_write", bus.rf_write, 1'b0);
`ifdef RF_SCHED_STATS_EN
    checkOutput("rst_stat_mc_writes",    stat_mc_writes,    16'd0);
    checkOutput("rst_stat_stall_cycles", stat_stall_cycles, 16'd0);
`endif
    modelClear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.wb_valid = 1'b0; bus.mc_valid = 1'b0;
  endtask

  initial begin
    int wb_pct;
    bit wbv;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.mc_valid = 1'b0; bus.mc_addr = '0; bus.mc_data = '0;
    bus.rd_addr1 = '0;   bus.rd_addr2 = '0; bus.id_dst  = '0;
    modelClear();
    doReset();

    // Idle push then drain
    applyStimulus(0, 0, '0, 1, 2, 16'h1234, 2, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, '0,       2, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, '0,       2, 0, 0);

    // Writeback starves a queued entry until the stall forces a gap
    applyStimulus(1, 0, 16'hAAAA, 1, 1, 16'h5555, 1, 1, 1);
    repeat (5) applyStimulus(1, 0, 16'hAAAA, 0, 0, '0, 1, 1, 1);
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 1, 1);
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 1, 1);

    // Fill the buffer, refuse a third, then drain
    applyStimulus(1, 0, 16'h0011, 1, 0, 16'h00A1, 0, 0, 0);
    applyStimulus(1, 0, 16'h0022, 1, 1, 16'h00B2, 0, 0, 0);
    applyStimulus(1, 0, 16'h0033, 1, 2, 16'h00C3, 2, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 0, 0);

    // Same-register ordering
    applyStimulus(0, 0, '0, 1, 3, 16'h0001, 3, 0, 0);
    applyStimulus(0, 0, '0, 1, 3, 16'h0002, 3, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, '0,       3, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, '0,       3, 0, 0);

    // Reset with a full buffer and wb_stall set, then confirm nothing leaks out
    applyStimulus(1, 0, 16'hBEEF, 1, 1, 16'h0101, 1, 2, 0);
    applyStimulus(1, 0, 16'hBEEF, 1, 2, 16'h0202, 1, 2, 0);
    repeat (5) applyStimulus(1, 0, 16'hBEEF, 0, 0, '0, 1, 2, 0);
    doReset();
    repeat (3) applyStimulus(0, 0, '0, 0, 0, '0, 1, 2, 0);

    // Randomized traffic with phases of light and heavy writeback
    wb_pct = 50;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       wb_pct = 10;
          1:       wb_pct = 50;
          default: wb_pct = 90;
        endcase
      end
      wbv = ($urandom_range(0, 99) < wb_pct);
      if (m_stall && $urandom_range(0, 3) != 0) wbv = 1'b0;
      applyStimulus(wbv, AW'($urandom_range(0, 3)), DW'($urandom()),
                    ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 3)), DW'($urandom()),
                    AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
      if (c == 300) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
RF_WRITE_SCHED -- requirements
Module: rf_write_sched

Interface
REQ-001 Parameter DW, default 16: write-data width in bits.
REQ-002 Parameter AW, default 2: register address width (4 registers).
REQ-003 Parameter DEPTH, default 2: entries in the secondary-writer buffer.
REQ-004 Parameter STARVE_LIMIT, default 4: consecutive blocked cycles before a writeback stall is forced.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with ports clk and reset as listed below.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 wb_valid  in  1  pipeline writeback request; it cannot be back-pressured.
REQ-009 wb_addr  in  AW  writeback destination register.
REQ-010 wb_data  in  DW  writeback data.
REQ-011 mc_valid  in  1  secondary-writer (multi-cycle unit or debug port) request.
REQ-012 mc_ready  out  1  secondary-writer accept.
REQ-013 mc_addr  in  AW  secondary-writer destination register.
REQ-014 mc_data  in  DW  secondary-writer data.
REQ-015 rd_addr1, rd_addr2, id_dst  in  AW each  decode-stage source and destination registers.
REQ-016 hazard  out  1  decode stage must stall.
REQ-017 wb_stall  out  1  upstream must not present wb_valid this cycle.
REQ-018 rf_write  out  1  register-file write enable.
REQ-019 rf_addr3  out  AW  register-file write address.
REQ-020 rf_data3  out  DW  register-file write data.

Function
REQ-021 mc_ready SHALL be 1 exactly when the buffer count is less than DEPTH; it SHALL depend only on registered state.
REQ-022 An mc_valid && mc_ready cycle SHALL push {mc_addr, mc_data} at the clock edge; data is never bypassed, so the earliest RF write of an entry is the following cycle.
REQ-023 The write port SHALL be driven combinationally as follows.
  - Priority 1: if wb_valid, rf_write = 1 with wb_addr/wb_data.
  - Priority 2: else if the buffer is non-empty, rf_write = 1 with the head entry, and the head is popped at the edge.
  - Otherwise rf_write = 0 and rf_addr3/rf_data3 = 0.
REQ-024 A push and a pop in the same cycle SHALL keep the count unchanged and preserve FIFO order; the read and write pointers SHALL wrap modulo DEPTH.
REQ-025 A pending vector SHALL have bit r set exactly when any valid buffer entry has address r.
REQ-026 hazard SHALL equal pending[rd_addr1] | pending[rd_addr2] | pending[id_dst], computed from registered state only.
REQ-027 A starvation counter SHALL operate as follows.
  - It increments each cycle the buffer is non-empty and wb_valid = 1.
  - It clears on any pop or when the buffer is empty.
  - It saturates at STARVE_LIMIT.
REQ-028 wb_stall SHALL be a register with this behaviour.
  - It sets at the edge on which the starvation counter reaches STARVE_LIMIT.
  - It clears at the edge of the next pop.
  - With DEPTH entries queued, it remains set until the buffer has drained by one entry.
REQ-029 If wb_valid is asserted while wb_stall = 1 (contract violation), writeback SHALL still win the port and the counter SHALL hold at STARVE_LIMIT.
REQ-030 If wb_addr equals the head address on a cycle where writeback wins, no special action SHALL occur; ordering is guaranteed upstream by hazard on id_dst.

Reset
REQ-031 Assertion of reset SHALL immediately clear the count, pointers, pending vector, starvation counter and wb_stall.
REQ-032 During reset, mc_ready = 1 (when DEPTH > 0), hazard = 0 and rf_write = 0.
REQ-033 Entries buffered when reset asserts SHALL be discarded without any RF write; buffer data storage need not be reset.

Configuration
REQ-034 With RF_SCHED_STATS_EN defined, the block SHALL expose two 16-bit saturating counters, both cleared by reset.
  - stat_mc_writes: counts buffered entries written to the RF.
  - stat_stall_cycles: counts cycles with wb_stall = 1.
REQ-035 Without RF_SCHED_STATS_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-036 A shared package SHALL hold the following.
  - Default constants: DW, AW, DEPTH, STARVE_LIMIT.
  - The buffer-entry struct {addr, data}.
REQ-037 The buffer SHALL be a single sub-module, rf_sched_fifo.
  - It provides push, pop, count, and per-entry valid/addr visibility for the pending vector.
  - Arbitration, pending and starvation logic stay in the top module.

Verification
REQ-038 Idle push: mc_valid = 1, addr 2, data 0x1234, wb_valid = 0 -> next cycle rf_write = 1, rf_addr3 = 2, rf_data3 = 0x1234; hazard high only for the cycle between push and pop.
REQ-039 Conflict: wb_valid held 1 (addr 0, data 0xAAAA) while one entry (addr 1) is queued -> RF sees only 0xAAAA writes; wb_stall rises after 4 blocked cycles; on the first cycle with wb_valid = 0, the entry writes and wb_stall falls.
REQ-040 Full buffer: two pushes with no pop -> mc_ready = 0; a third mc_valid is not accepted; one pop -> mc_ready = 1 the next cycle.
REQ-041 Ordering: push addr 3 data 0x0001 then addr 3 data 0x0002 -> RF writes 0x0001 then 0x0002; hazard on rd_addr1 = 3 holds until the second write completes.
REQ-042 Reset mid-operation: two entries queued and wb_stall = 1, then reset asserted asynchronously -> mc_ready = 1, hazard = 0, wb_stall = 0 immediately; no buffered write reaches the RF afterwards.
REQ-043 With RF_SCHED_STATS_EN: drain 3 entries and 5 stall cycles -> stat_mc_writes = 3, stat_stall_cycles = 5.
